// File: rtl/logic_unit_scheduler_if.sv
// Request/response bundle for logic_unit_scheduler: two requester channels plus one response channel.
// Latency: none, signal grouping only.
// Backpressure: valid/ready on every channel; the master drives requests and rsp_ready, the slave (scheduler) drives readys and rsp_*.
// Ports: req0_*/req1_* (valid, ready, a, b, op), rsp_* (valid, ready, data, id, err).
interface logic_unit_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_err;

  // Requester/consumer side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_data, rsp_id, rsp_err
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/logic_unit_scheduler.sv
// Round-robin scheduler sharing one AND/OR logic unit between two requesters.
// Latency: 1 cycle from request accept to rsp_valid; one op in flight, so at most one op per 2 cycles.
// Backpressure: response held stable until rsp_ready; no request is accepted while a response is pending.
// Ports: clk, rst_n (async active-low), ena (grant enable), bus (slave modport: req0/req1/rsp channels),
//        busy (not IDLE), op_count (completed response handshakes, wraps at 256).
// Optional feature: define LOGIC_UNIT_SCHED_XOR_EN to enable XOR (op 10) and NAND (op 11);
// without it those ops complete with rsp_data = 0 and rsp_err = 1.
module logic_unit_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  logic_unit_scheduler_if.slave       bus,
  output logic                        busy,
  output logic [7:0]                  op_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]       state;
  logic             last_grant;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_id_q;
  logic             rsp_err_q;

  logic             is_idle;
  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] res_data;
  logic             res_err;

  assign is_idle = (state == ST_IDLE);

  // Arbitration: a lone requester wins outright; under contention the one
  // that did not win last time goes next. The granted requester is valid by
  // construction, so a grant is also an accept.
  always_comb begin
    grant_vld = is_idle && ena && (bus.req0_valid || bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = ~bus.req0_valid;
    end
  end

  assign bus.req0_ready = grant_vld && !grant_id;
  assign bus.req1_ready = grant_vld &&  grant_id;

  // Operand mux feeding the shared unit.
  always_comb begin
    sel_a  = bus.req0_a;
    sel_b  = bus.req0_b;
    sel_op = bus.req0_op;
    if (grant_id) begin
      sel_a  = bus.req1_a;
      sel_b  = bus.req1_b;
      sel_op = bus.req1_op;
    end
  end

  // Shared logic unit, purely bitwise at WIDTH.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (sel_op)
      2'b00: res_data = sel_a & sel_b;
      2'b01: res_data = sel_a | sel_b;
`ifdef LOGIC_UNIT_SCHED_XOR_EN
      2'b10: res_data = sel_a ^ sel_b;
      default: res_data = ~(sel_a & sel_b);
`else
      default: begin
        res_data = '0;
        res_err  = 1'b1;
      end
`endif
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            state      <= ST_RESP;
            last_grant <= grant_id;
            rsp_data_q <= res_data;
            rsp_id_q   <= grant_id;
            rsp_err_q  <= res_err;
          end
        end
        default: begin
          // ena is deliberately ignored here: a pending response always drains.
          if (bus.rsp_ready) begin
            state    <= ST_IDLE;
            op_count <= op_count + 8'd1;
          end
        end
      endcase
    end
  end

  // A response is pending exactly when the FSM sits in RESP.
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = !is_idle;

endmodule

// File: doc/logic_unit_scheduler.md
Name: logic_unit_scheduler

Overview:
- Shares one AND/OR logic unit between two requesters (req0, req1) using round-robin arbitration.
- One operation in flight at a time; result is registered and returned on a valid/ready response channel tagged with the requester ID.
- Sits between the tt_um top-level pin mapping and the AND/OR datapath, so both the pin-driven path and the internal test sequencer can use the unit.

Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- clk  input  1  system clock; rising-edge.
- rst_n  input  1  asynchronous, active-low reset; one clock domain only.
- ena  input  1  grant enable; when low, no new grants are made, and an in-flight response still completes.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as req0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_data  output  WIDTH  result.
- rsp_id  output  1  requester that issued the operation.
- rsp_err  output  1  unsupported op code.
- busy  output  1  high when state is not IDLE.
- op_count  output  8  completed response handshakes; wraps 255 -> 0.

Behaviour:
- FSM states: IDLE, RESP.
- Reset (async, rst_n low) sets all of the following immediately, independent of clk:
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_id = 0; rsp_err = 0.
  - op_count = 0; rr pointer last_grant = 1, so req0 wins first.
  - Any in-flight operation is discarded.
- Arbitration happens in IDLE with ena = 1:
  - Only one valid: that requester wins.
  - Both valid: the requester other than last_grant wins.
  - Neither valid, or ena = 0: no grant.
- reqN_ready is combinational and equals (state == IDLE) && ena && (grant == N).
  - At most one ready is high in any cycle.
  - Ready never depends on rsp_ready.
- Accept cycle (valid && ready for requester N):
  - Operands and op are used that cycle.
  - Result is registered into rsp_data; rsp_id = N; last_grant = N; state goes to RESP.
  - rsp_valid = 1 from the next cycle. Latency is 1 cycle from accept to rsp_valid.
- Op encoding:
  - 00: a & b.
  - 01: a | b.
  - 10 and 11: handled per the optional feature.
- RESP state:
  - rsp_valid, rsp_data, rsp_id and rsp_err hold stable until rsp_ready = 1.
  - On that handshake: rsp_valid = 0, op_count += 1 (mod 256), state = IDLE.
  - No request is accepted in RESP, so peak throughput is one operation per 2 cycles when rsp_ready is tied high.
- ena deasserted while in RESP has no effect on the pending response.
- A requester dropping valid before ready is legal; no state changes.
- Requester operands must stay stable while valid is high and ready is low (protocol rule, not checked).
- Fairness: with both requesters continuously valid and rsp_ready = 1, grants alternate 0,1,0,1…
- Results are truncated/computed bitwise at WIDTH; no carries.

Optional Feature:
- Macro: LOGIC_UNIT_SCHED_XOR_EN.
- Defined:
  - op 10 gives a ^ b; op 11 gives ~(a & b).
  - rsp_err is always 0.
- Undefined:
  - ops 10 and 11 are still accepted and sequenced normally.
  - rsp_data = 0 and rsp_err = 1 for those ops; ops 00 and 01 are unaffected.

Test Plan:
- Reset then single op: req0 with a = 0x14, b = 0x1E, op 00 -> req0_ready high in the accept cycle; next cycle rsp_valid = 1, rsp_data = 0x14, rsp_id = 0; op_count = 1 after the handshake.
- Contention: both requesters valid. req0 has a = 0x94, b = 0x1E, op 01; req1 has a = 0x00, b = 0x00, op 00. rsp_ready = 1 -> first response is id 0 with data 0x9E, second is id 1 with data 0x00; four back-to-back ops alternate 0,1,0,1.
- Backpressure: rsp_ready = 0 for 5 cycles after a response -> rsp_* stable, busy = 1, both readys low; releasing rsp_ready returns to IDLE the next cycle.
- Optional op: a = 0xFF, b = 0xAA, op 10:
  - Macro defined -> rsp_data = 0x55, rsp_err = 0.
  - Macro undefined -> rsp_data = 0x00, rsp_err = 1.
- ena low with both requesters valid for 4 cycles -> no ready and no rsp_valid; ena high -> the grant goes per last_grant.
- Async reset asserted mid-RESP, off a clock edge -> rsp_valid = 0 and op_count = 0 immediately; after release, req0 wins first under contention.
